// File: rtl/pf_pkg.sv
// Shared definitions for the p-1 factoriser blocks: sieve FSM states and
// sizing helpers.
package pf_pkg;

   localparam int unsigned PRIME_MAX_N_DEFAULT = 512;

   typedef enum logic [2:0] {
      S_INIT,
      S_OUTER,
      S_MARK,
      S_COMPACT,
      S_READY
   } sieve_state_t;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned v;
      int unsigned w;
      w = 0;
      v = value - 1;
      while (v > 0) begin
         w++;
         v = v >> 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/prime_table_ram.sv
// Compacted prime table: one write port fed by the sieve compaction, one
// registered read port that provides the single-cycle lookup latency.
module prime_table_ram
   import pf_pkg::*;
#(
   parameter int unsigned DEPTH = 128,
   parameter int unsigned WIDTH = 9,
   localparam int unsigned AW   = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read register only updates on a real lookup so the value holds between requests.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/prime_sieve_table.sv
// Self-initialising prime table: sieves [0, MAX_N) after reset, compacts the
// primes into a RAM, then serves index lookups and primality queries.
module prime_sieve_table
   import pf_pkg::*;
#(
   parameter int unsigned MAX_N      = PRIME_MAX_N_DEFAULT,
   parameter int unsigned DATA_W     = clog2(MAX_N),
   parameter int unsigned IDX_W      = 13,
   parameter int unsigned MAX_PRIMES = 128
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              mode,
   input  logic [IDX_W-1:0]  index,
   output logic              ready,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic              err,
   output logic [IDX_W-1:0]  count
);

   localparam int unsigned       AW        = clog2(MAX_PRIMES);
   localparam int unsigned       PW        = 2 * (DATA_W + 1);
   localparam logic [PW-1:0]     PP_LIMIT  = PW'(MAX_N);
   localparam logic [DATA_W:0]   M_LIMIT   = (DATA_W + 1)'(MAX_N);
   localparam logic [DATA_W-1:0] N_LAST    = DATA_W'(MAX_N - 1);
   localparam logic [IDX_W-1:0]  COUNT_MAX = IDX_W'(MAX_PRIMES);
   localparam logic [IDX_W-1:0]  N_LIMIT   = IDX_W'(MAX_N);

   sieve_state_t      state;
   sieve_state_t      state_next;
   logic [MAX_N-1:0]  bitmap;
   logic [DATA_W:0]   p;
   logic [DATA_W:0]   m;
   logic [DATA_W:0]   m_step;
   logic [PW-1:0]     p_sq;
   logic [DATA_W-1:0] n;
   logic              sieve_done;
   logic              mark_done;
   logic              keep;
   logic              tbl_we;

   logic              accept;
   logic              idx_in_range;
   logic              val_in_range;
   logic              rd_en;
   logic [AW-1:0]     rd_addr;
   logic              sel_ram;
   logic [DATA_W-1:0] ram_q;
   logic [DATA_W-1:0] imm_data;

   // Squares and strides are widened so the loop-exit compares never wrap.
   assign p_sq       = PW'(p) * PW'(p);
   assign m_step     = m + p;
   assign sieve_done = (p_sq >= PP_LIMIT);
   assign mark_done  = (m_step >= M_LIMIT);
   assign keep       = bitmap[n] && (count != COUNT_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_INIT;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      ready      = 1'b0;
      tbl_we     = 1'b0;
      unique case (state)
         S_INIT: begin
            state_next = S_OUTER;
         end
         S_OUTER: begin
            if (sieve_done) begin
               state_next = S_COMPACT;
            end else if (bitmap[p[DATA_W-1:0]]) begin
               state_next = S_MARK;
            end
         end
         S_MARK: begin
            if (mark_done) begin
               state_next = S_OUTER;
            end
         end
         S_COMPACT: begin
            tbl_we = keep;
            if (n == N_LAST) begin
               state_next = S_READY;
            end
         end
         S_READY: begin
            ready = 1'b1;
         end
         default: begin
            state_next = S_INIT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p     <= '0;
         m     <= '0;
         n     <= '0;
         count <= '0;
      end else begin
         unique case (state)
            S_INIT: begin
               bitmap <= {{(MAX_N - 2){1'b1}}, 2'b00};
               p      <= (DATA_W + 1)'(2);
               count  <= '0;
            end
            S_OUTER: begin
               if (sieve_done) begin
                  n     <= DATA_W'(2);
                  count <= '0;
               end else if (bitmap[p[DATA_W-1:0]]) begin
                  m <= p_sq[DATA_W:0];
               end else begin
                  p <= p + 1'b1;
               end
            end
            S_MARK: begin
               bitmap[m[DATA_W-1:0]] <= 1'b0;
               m                     <= m_step;
               if (mark_done) begin
                  p <= p + 1'b1;
               end
            end
            S_COMPACT: begin
               if (keep) begin
                  count <= count + 1'b1;
               end
               n <= n + 1'b1;
            end
            default: ;
         endcase
      end
   end

   table_overflow: assert property (@(posedge clk) disable iff (rst)
      !(state == S_COMPACT && bitmap[n] && count == COUNT_MAX));

   assign accept       = req && ready;
   assign idx_in_range = (index != '0) && (index <= count);
   assign val_in_range = (index < N_LIMIT);
   assign rd_en        = accept && !mode && idx_in_range;
   assign rd_addr      = AW'(index - 1'b1);

   // RAM hits come from the read register, everything else from imm_data;
   // both hold while idle so data keeps its last value.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid    <= 1'b0;
         err      <= 1'b0;
         sel_ram  <= 1'b0;
         imm_data <= '0;
      end else begin
         valid <= accept;
         if (accept) begin
            sel_ram <= rd_en;
            if (mode) begin
               err      <= !val_in_range;
               imm_data <= val_in_range ? DATA_W'(bitmap[index[DATA_W-1:0]]) : '0;
            end else begin
               err      <= !idx_in_range;
               imm_data <= '0;
            end
         end
      end
   end

   assign data = sel_ram ? ram_q : imm_data;

   prime_table_ram #(
      .DEPTH (MAX_PRIMES),
      .WIDTH (DATA_W)
   ) u_table (
      .clk   (clk),
      .rst   (rst),
      .we    (tbl_we),
      .waddr (count[AW-1:0]),
      .wdata (n),
      .re    (rd_en),
      .raddr (rd_addr),
      .rdata (ram_q)
   );

endmodule

// File: tb/tb_prime_sieve_table.sv
// Bench for prime_sieve_table: trial-division prime model, randomized lookups,
// directed boundary cases, mid-build reset and a small-bound second instance.
module tb_prime_sieve_table;

   localparam int N_A = 512;
   localparam int N_B = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, req_a, mode_a;
   logic [12:0] index_a;
   logic        ready_a, valid_a, err_a;
   logic [8:0]  data_a;
   logic [12:0] count_a;

   logic        rst_b, req_b, mode_b;
   logic [12:0] index_b;
   logic        ready_b, valid_b, err_b;
   logic [5:0]  data_b;
   logic [12:0] count_b;

   prime_sieve_table #(
      .MAX_N      (N_A),
      .DATA_W     (9),
      .IDX_W      (13),
      .MAX_PRIMES (128)
   ) dut_a (
      .clk   (clk),
      .rst   (rst_a),
      .req   (req_a),
      .mode  (mode_a),
      .index (index_a),
      .ready (ready_a),
      .valid (valid_a),
      .data  (data_a),
      .err   (err_a),
      .count (count_a)
   );

   prime_sieve_table #(
      .MAX_N      (N_B),
      .DATA_W     (6),
      .IDX_W      (13),
      .MAX_PRIMES (32)
   ) dut_b (
      .clk   (clk),
      .rst   (rst_b),
      .req   (req_b),
      .mode  (mode_b),
      .index (index_b),
      .ready (ready_b),
      .valid (valid_b),
      .data  (data_b),
      .err   (err_b),
      .count (count_b)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
      end
   endtask

   // Reference: primality by trial division, primes listed in ascending order.
   int primes [$];

   function automatic bit is_prime(input int v);
      if (v < 2) return 1'b0;
      for (int d = 2; d * d <= v; d++) begin
         if (v % d == 0) return 1'b0;
      end
      return 1'b1;
   endfunction

   typedef struct packed {
      logic       v;
      logic [8:0] d;
      logic       e;
   } exp_t;

   function automatic exp_t model(input bit md, input int idx);
      exp_t r;
      r.v = 1'b1;
      if (!md) begin
         if (idx >= 1 && idx <= primes.size()) begin
            r.d = 9'(primes[idx-1]);
            r.e = 1'b0;
         end else begin
            r.d = '0;
            r.e = 1'b1;
         end
      end else begin
         if (idx < N_A) begin
            r.d = 9'(is_prime(idx));
            r.e = 1'b0;
         end else begin
            r.d = '0;
            r.e = 1'b1;
         end
      end
      return r;
   endfunction

   // drv_exp describes the request presented before the next edge; cur_exp is
   // what that request must produce after the edge.
   exp_t       drv_exp = '0;
   exp_t       cur_exp = '0;
   logic [8:0] last_d  = '0;
   logic       last_e  = 1'b0;
   bit         mon_on  = 1'b0;

   always @(posedge clk) begin
      cur_exp <= drv_exp;
      if (rst_a) begin
         last_d <= '0;
         last_e <= 1'b0;
      end else if (drv_exp.v) begin
         last_d <= drv_exp.d;
         last_e <= drv_exp.e;
      end
   end

   always @(negedge clk) begin
      if (mon_on) begin
         chk("valid", 32'(valid_a), 32'(cur_exp.v));
         chk("data", 32'(data_a), 32'(last_d));
         chk("err", 32'(err_a), 32'(last_e));
      end
   end

   task automatic issue_a(input bit md, input int idx, input exp_t e);
      req_a   = 1'b1;
      mode_a  = md;
      index_a = 13'(idx);
      drv_exp = e;
      @(posedge clk);
      #1;
   endtask

   task automatic lookup_a(input bit md, input int idx, input bit ee, input int ed);
      exp_t e;
      e.v = 1'b1;
      e.d = 9'(ed);
      e.e = ee;
      issue_a(md, idx, e);
   endtask

   task automatic idle_a(input int n);
      req_a   = 1'b0;
      drv_exp = '0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Requests are thrown at the DUT while it builds; none may be accepted.
   task automatic wait_ready_a(output int cyc);
      cyc = 0;
      drv_exp = '0;
      while (ready_a !== 1'b1 && cyc < 2600) begin
         req_a   = 1'($urandom_range(0, 1));
         mode_a  = 1'($urandom_range(0, 1));
         index_a = 13'($urandom_range(0, 600));
         @(posedge clk);
         #1;
         cyc++;
      end
      req_a = 1'b0;
   endtask

   task automatic random_a(input int n);
      exp_t e;
      bit   md;
      int   idx;
      for (int k = 0; k < n; k++) begin
         md  = 1'($urandom_range(0, 1));
         idx = md ? int'($urandom_range(0, 700)) : int'($urandom_range(0, 100));
         e   = model(md, idx);
         issue_a(md, idx, e);
         if ($urandom_range(0, 3) == 0) idle_a(1);
      end
      idle_a(1);
   endtask

   task automatic build_checks(input string tag);
      int cyc;
      wait_ready_a(cyc);
      chk({tag, "_ready"}, 32'(ready_a), 32'd1);
      chk({tag, "_min_build"}, 32'(cyc >= N_A), 32'd1);
      chk({tag, "_max_build"}, 32'(cyc < 2600), 32'd1);
      chk({tag, "_count"}, 32'(count_a), 32'd97);
   endtask

   task automatic lookup_b(input bit md, input int idx, input bit ee, input int ed);
      req_b   = 1'b1;
      mode_b  = md;
      index_b = 13'(idx);
      @(posedge clk);
      #1;
      req_b = 1'b0;
      chk("b_valid", 32'(valid_b), 32'd1);
      chk("b_data", 32'(data_b), 32'(ed));
      chk("b_err", 32'(err_b), 32'(ee));
      @(posedge clk);
      #1;
      chk("b_valid_drop", 32'(valid_b), 32'd0);
      chk("b_data_hold", 32'(data_b), 32'(ed));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_a = 1'b1; req_a = 1'b0; mode_a = 1'b0; index_a = '0;
      rst_b = 1'b1; req_b = 1'b0; mode_b = 1'b0; index_b = '0;

      for (int v = 0; v < N_A; v++) begin
         if (is_prime(v)) primes.push_back(v);
      end
      chk("model_pi", 32'(primes.size()), 32'd97);
      chk("model_p12", 32'(primes[11]), 32'd37);
      chk("model_p97", 32'(primes[96]), 32'd509);

      @(posedge clk);
      #1;
      mon_on = 1'b1;
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      chk("rst_ready", 32'(ready_a), 32'd0);
      chk("rst_count", 32'(count_a), 32'd0);
      chk("rst_ready_b", 32'(ready_b), 32'd0);

      rst_a = 1'b0;
      rst_b = 1'b0;
      build_checks("build");

      lookup_a(1'b0, 1, 1'b0, 2);    idle_a(1);
      lookup_a(1'b0, 2, 1'b0, 3);    idle_a(1);
      lookup_a(1'b0, 3, 1'b0, 5);    idle_a(1);
      lookup_a(1'b0, 12, 1'b0, 37);  idle_a(1);
      lookup_a(1'b0, 97, 1'b0, 509); idle_a(2);

      lookup_a(1'b0, 0, 1'b1, 0);    idle_a(1);
      lookup_a(1'b0, 98, 1'b1, 0);   idle_a(1);
      lookup_a(1'b1, 511, 1'b0, 0);  idle_a(1);
      lookup_a(1'b1, 509, 1'b0, 1);  idle_a(1);
      lookup_a(1'b1, 600, 1'b1, 0);  idle_a(1);
      lookup_a(1'b1, 2, 1'b0, 1);    idle_a(1);
      lookup_a(1'b1, 1, 1'b0, 0);    idle_a(2);

      lookup_a(1'b0, 4, 1'b0, 7);
      lookup_a(1'b0, 5, 1'b0, 11);
      lookup_a(1'b0, 6, 1'b0, 13);
      lookup_a(1'b0, 7, 1'b0, 17);
      idle_a(2);

      random_a(300);
      chk("count_stable", 32'(count_a), 32'd97);

      rst_a = 1'b1;
      idle_a(1);
      chk("rst_from_ready", 32'(ready_a), 32'd0);
      rst_a = 1'b0;
      idle_a(10);
      rst_a = 1'b1;
      idle_a(1);
      chk("rst_mid_mark_ready", 32'(ready_a), 32'd0);
      chk("rst_mid_mark_count", 32'(count_a), 32'd0);
      idle_a(1);
      rst_a = 1'b0;
      build_checks("rebuild");
      random_a(100);

      chk("b_ready", 32'(ready_b), 32'd1);
      chk("b_count", 32'(count_b), 32'd18);
      lookup_b(1'b0, 18, 1'b0, 61);
      lookup_b(1'b0, 1, 1'b0, 2);
      lookup_b(1'b0, 19, 1'b1, 0);
      lookup_b(1'b1, 61, 1'b0, 1);
      lookup_b(1'b1, 63, 1'b0, 0);
      lookup_b(1'b1, 64, 1'b1, 0);

      idle_a(3);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
